vga_frame_capture: RTL and testbench

- Receive side of the VGA interface: samples Hsync/Vsync and 4-bit Red/Green/Blue from a VGA timing source in the same clock domain.
- Tracks column and row position from the sync edges and packs active-region pixels into 12-bit words.
- Writes those words linearly into a frame buffer.
- Frame capture is armed by a Start pulse; the block is used for loopback checking of the display path and for frame grabbing.

---
 rtl/vga_frame_capture.sv | 163 ++++++++++++++++
 tb/tb_vga_frame_capture.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// VGA receive path: follows sync edges to locate the active window and, once armed,
// streams one frame of packed pixels into a linear frame-buffer write port.
module vga_frame_capture #(
    parameter int COLOR_WIDTH   = 4,
    parameter int DATA_WIDTH    = 12,
    parameter int REZ_MAX_WIDTH = 11,
    parameter int ADDR_WIDTH    = 19,
    parameter int H_START       = 144,
    parameter int H_ACTIVE      = 640,
    parameter int V_START       = 35,
    parameter int V_ACTIVE      = 480
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Start,
    input  logic                   Hsync,
    input  logic                   Vsync,
    input  logic [COLOR_WIDTH-1:0] Red,
    input  logic [COLOR_WIDTH-1:0] Green,
    input  logic [COLOR_WIDTH-1:0] Blue,
    output logic                   Wr_en,
    output logic [ADDR_WIDTH-1:0]  Wr_addr,
    output logic [DATA_WIDTH-1:0]  Wr_data,
    output logic                   Busy,
    output logic                   Frame_done,
    output logic                   Frame_err
);

    localparam logic [REZ_MAX_WIDTH-1:0] REZ_MAX = '1;
    localparam logic [REZ_MAX_WIDTH-1:0] H_FIRST = REZ_MAX_WIDTH'(H_START);
    localparam logic [REZ_MAX_WIDTH-1:0] H_LAST  = REZ_MAX_WIDTH'(H_START + H_ACTIVE - 1);
    localparam logic [REZ_MAX_WIDTH-1:0] V_FIRST = REZ_MAX_WIDTH'(V_START);
    localparam logic [REZ_MAX_WIDTH-1:0] V_LAST  = REZ_MAX_WIDTH'(V_START + V_ACTIVE - 1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_MAX = '1;
    // Two spare bits so writes past a saturated address still register as a count error.
    localparam int                       CNT_WIDTH   = ADDR_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0]     CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0]     FRAME_WORDS = CNT_WIDTH'(H_ACTIVE * V_ACTIVE);

    // state   | meaning
    // IDLE    | not capturing, waiting for Start
    // ARMED   | Start accepted, waiting for the frame-opening Vsync edge
    // CAPTURE | writing active pixels until the next Vsync edge
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    state_t                   state;
    logic                     hsync_s1, vsync_s1, hsync_s2, vsync_s2;
    logic [COLOR_WIDTH-1:0]   red_s1, green_s1, blue_s1;
    logic [REZ_MAX_WIDTH-1:0] col_q, row_q, col_cur, row_cur;
    logic                     h_fall, v_fall, active;
    logic [DATA_WIDTH-1:0]    pixel;
    logic [ADDR_WIDTH-1:0]    next_addr;
    logic [CNT_WIDTH-1:0]     wr_count, final_count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hsync_s1 <= 1'b1;
            vsync_s1 <= 1'b1;
            hsync_s2 <= 1'b1;
            vsync_s2 <= 1'b1;
            red_s1   <= '0;
            green_s1 <= '0;
            blue_s1  <= '0;
        end else begin
            hsync_s1 <= Hsync;
            vsync_s1 <= Vsync;
            hsync_s2 <= hsync_s1;
            vsync_s2 <= vsync_s1;
            red_s1   <= Red;
            green_s1 <= Green;
            blue_s1  <= Blue;
        end
    end

    assign h_fall = !hsync_s1 && hsync_s2;
    assign v_fall = !vsync_s1 && vsync_s2;

    // Position of the sample currently in S1; the registers hold the previous sample's position.
    always_comb begin
        col_cur = col_q;
        row_cur = row_q;
        if (h_fall)
            col_cur = '0;
        else if (col_q != REZ_MAX)
            col_cur = col_q + REZ_MAX_WIDTH'(1);
        if (v_fall)
            row_cur = '0;
        else if (h_fall && row_q != REZ_MAX)
            row_cur = row_q + REZ_MAX_WIDTH'(1);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_cur;
            row_q <= row_cur;
        end
    end

    assign active = (col_cur >= H_FIRST) && (col_cur <= H_LAST) &&
                    (row_cur >= V_FIRST) && (row_cur <= V_LAST);
    assign pixel  = DATA_WIDTH'({blue_s1, green_s1, red_s1});

    // Count including a write issued in the same sample as the closing Vsync edge.
    assign final_count = (active && wr_count != CNT_MAX) ? wr_count + CNT_WIDTH'(1) : wr_count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            Wr_en      <= 1'b0;
            Wr_addr    <= '0;
            Wr_data    <= '0;
            Busy       <= 1'b0;
            Frame_done <= 1'b0;
            Frame_err  <= 1'b0;
            next_addr  <= '0;
            wr_count   <= '0;
        end else begin
            Wr_en      <= 1'b0;
            Frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= ARMED;
                        Busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (v_fall) begin
                        state     <= CAPTURE;
                        next_addr <= '0;
                        Wr_addr   <= '0;
                        wr_count  <= '0;
                        Frame_err <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (active) begin
                        Wr_en    <= 1'b1;
                        Wr_addr  <= next_addr;
                        Wr_data  <= pixel;
                        wr_count <= final_count;
                        if (next_addr != ADDR_MAX)
                            next_addr <= next_addr + ADDR_WIDTH'(1);
                    end
                    if (v_fall) begin
                        state      <= IDLE;
                        Busy       <= 1'b0;
                        Frame_done <= 1'b1;
                        Frame_err  <= (final_count != FRAME_WORDS);
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture with a small 4x3 active window; frames are generated line by
// line and the expected write/done stream is derived from the generator's own line/column loops.
module tb_vga_frame_capture;

    localparam int HS    = 2;
    localparam int HA    = 4;
    localparam int VS    = 1;
    localparam int VA    = 3;
    localparam int LINES = 6;
    localparam int WORDS = HA * VA;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [3:0]  red = '0, green = '0, blue = '0;
    logic        wr_en, busy, frame_done, frame_err;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;

    int tests = 0, fails = 0, cyc = 0;

    typedef enum {M_IDLE, M_ARMED, M_CAP} mstate_t;
    typedef struct packed {int cyc; int addr; logic [11:0] data;} wr_t;
    typedef struct packed {int cyc; logic err; logic busy;} done_t;

    mstate_t m_state = M_IDLE;
    int      m_cnt = 0;
    wr_t     exp_w[$], act_w[$];
    done_t   exp_d[$], act_d[$];
    wr_t     mon_w;
    done_t   mon_d;

    vga_frame_capture #(
        .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA)
    ) dut (
        .Clk(clk), .Rst(rst), .Start(start), .Hsync(hsync), .Vsync(vsync),
        .Red(red), .Green(green), .Blue(blue),
        .Wr_en(wr_en), .Wr_addr(wr_addr), .Wr_data(wr_data),
        .Busy(busy), .Frame_done(frame_done), .Frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en === 1'b1) begin
                mon_w = '{cyc, int'(wr_addr), wr_data};
                act_w.push_back(mon_w);
            end
            if (frame_done === 1'b1) begin
                mon_d = '{cyc, frame_err, busy};
                act_d.push_back(mon_d);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end

    task automatic drive(input logic hs, input logic vs, input logic st, input logic [11:0] pix);
        @(posedge clk);
        #1;
        hsync = hs;
        vsync = vs;
        start = st;
        {blue, green, red} = pix;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 12'($urandom));
    endtask

    task automatic pulse_start();
        drive(1'b1, 1'b1, 1'b1, 12'($urandom));
        if (m_state == M_IDLE) m_state = M_ARMED;
        drive(1'b1, 1'b1, 1'b0, 12'($urandom));
    endtask

    // Line 0 carries the Vsync fall (at vs_col, or a random blanking column when vs_col < 0);
    // line index is the row, column index is the column.
    task automatic send_frame(input int vs_col, input int trunc_line, input int st_line,
                              input int st_col, input bit pat);
        int len, vcol;
        for (int ln = 0; ln < LINES; ln++) begin
            len = (ln == trunc_line) ? HS + HA - 1 : 8 + int'($urandom_range(3));
            if (ln == 0) vcol = (vs_col >= 0) ? vs_col : int'($urandom_range(len - 1, HS + HA));
            for (int c = 0; c < len; c++) begin
                logic [11:0] pix;
                bit st, vfall, act;
                pix   = pat ? 12'(ln * 16 + c) : 12'($urandom);
                st    = (ln == st_line) && (c == st_col);
                vfall = (ln == 0) && (c == vcol);
                act   = (ln >= VS) && (ln < VS + VA) && (c >= HS) && (c < HS + HA);
                drive(c != 0, !((ln == 0) && (c >= vcol)), st, pix);
                if (st && m_state == M_IDLE) m_state = M_ARMED;
                if (vfall) begin
                    if (m_state == M_CAP) begin
                        exp_d.push_back('{cyc + 2, logic'(m_cnt != WORDS), 1'b0});
                        m_state = M_IDLE;
                    end else if (m_state == M_ARMED) begin
                        m_state = M_CAP;
                        m_cnt   = 0;
                    end
                end
                if (m_state == M_CAP && act) begin
                    exp_w.push_back('{cyc + 2, m_cnt, pix});
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic clear_queues();
        exp_w.delete();
        act_w.delete();
        exp_d.delete();
        act_d.delete();
    endtask

    task automatic test_reset();
        bit got;
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_err} !== '0) begin
            fails++;
            $display("FAIL reset_async: got en %b addr %0d data %h busy %b done %b err %b want all 0",
                     wr_en, wr_addr, wr_data, busy, frame_done, frame_err);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_queues();
        m_state = M_IDLE;
        pulse_start();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_busy_after_start: got %b want 1", busy);
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            drive(i % 10 != 0, i >= 10, 1'b0, 12'($urandom));
            if (wr_en === 1'b1) got = 1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL reset_wait_write: got no write in 40 cycles want a write");
        end
        rst = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_err} !== '0) begin
            fails++;
            $display("FAIL reset_mid_capture: got en %b addr %0d data %h busy %b done %b err %b want all 0",
                     wr_en, wr_addr, wr_data, busy, frame_done, frame_err);
        end
        rst = 1'b0;
        clear_queues();
        m_state = M_IDLE;
        idle(3);
        tests++;
        if (act_w.size() != 0 || act_d.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_quiet: got %0d writes %0d dones busy %b want 0 0 0",
                     act_w.size(), act_d.size(), busy);
        end
        pulse_start();
        send_frame(-1, -1, -1, -1, 1'b0);
        send_frame(-1, -1, -1, -1, 1'b0);
        idle(4);
        tests++;
        if (act_d.size() != 1 || act_d.size() != exp_d.size() || act_d[0] !== exp_d[0]) begin
            fails++;
            $display("FAIL reset_recapture_done: got %0d dones (err %b) want 1 done err 0",
                     act_d.size(), (act_d.size() > 0) ? act_d[0].err : 1'bx);
        end
        tests++;
        if (act_w.size() != exp_w.size()) begin
            fails++;
            $display("FAIL reset_recapture_nwrites: got %0d want %0d", act_w.size(), exp_w.size());
        end
    endtask

    task automatic test_pattern_frame();
        clear_queues();
        pulse_start();
        send_frame(-1, -1, -1, -1, 1'b1);
        send_frame(-1, -1, -1, -1, 1'b1);
        idle(4);
        tests++;
        if (act_w.size() != WORDS || exp_w.size() != WORDS) begin
            fails++;
            $display("FAIL pattern_nwrites: got %0d want %0d (model %0d)", act_w.size(), WORDS, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
            tests++;
            if (act_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL pattern_write[%0d]: got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_w[i].cyc, act_w[i].addr, act_w[i].data,
                         exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        tests++;
        if (act_d.size() != 1 || exp_d.size() != 1 || act_d[0] !== exp_d[0]) begin
            fails++;
            $display("FAIL pattern_done: got %0d dones cyc %0d err %b busy %b want 1 done cyc %0d err 0 busy 0",
                     act_d.size(), (act_d.size() > 0) ? act_d[0].cyc : -1,
                     (act_d.size() > 0) ? act_d[0].err : 1'bx, (act_d.size() > 0) ? act_d[0].busy : 1'bx,
                     (exp_d.size() > 0) ? exp_d[0].cyc : -1);
        end
    endtask

    task automatic test_midframe_start();
        clear_queues();
        send_frame(-1, -1, 2, 3, 1'b0);
        tests++;
        if (act_w.size() != 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midstart_armed: got %0d writes busy %b want 0 writes busy 1", act_w.size(), busy);
        end
        send_frame(-1, -1, -1, -1, 1'b0);
        send_frame(-1, -1, -1, -1, 1'b0);
        idle(4);
        tests++;
        if (act_w.size() != exp_w.size()) begin
            fails++;
            $display("FAIL midstart_nwrites: got %0d want %0d", act_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
            tests++;
            if (act_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL midstart_write[%0d]: got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_w[i].cyc, act_w[i].addr, act_w[i].data,
                         exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        tests++;
        if (act_d.size() != 1 || exp_d.size() != 1 || act_d[0] !== exp_d[0]) begin
            fails++;
            $display("FAIL midstart_done: got %0d dones want 1 matching done at cyc %0d",
                     act_d.size(), (exp_d.size() > 0) ? exp_d[0].cyc : -1);
        end
    endtask

    task automatic test_truncated_line();
        clear_queues();
        pulse_start();
        send_frame(-1, 2, -1, -1, 1'b0);
        send_frame(-1, -1, -1, -1, 1'b0);
        idle(4);
        tests++;
        if (act_w.size() != WORDS - 1 || exp_w.size() != WORDS - 1) begin
            fails++;
            $display("FAIL trunc_nwrites: got %0d want %0d (model %0d)", act_w.size(), WORDS - 1, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
            tests++;
            if (act_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL trunc_write[%0d]: got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_w[i].cyc, act_w[i].addr, act_w[i].data,
                         exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        tests++;
        if (act_d.size() != 1 || exp_d.size() != 1 || act_d[0] !== exp_d[0] || act_d[0].err !== 1'b1) begin
            fails++;
            $display("FAIL trunc_done: got %0d dones err %b want 1 done err 1",
                     act_d.size(), (act_d.size() > 0) ? act_d[0].err : 1'bx);
        end
        tests++;
        if (frame_err !== 1'b1) begin
            fails++;
            $display("FAIL trunc_err_sticky: got %b want 1", frame_err);
        end
    endtask

    task automatic test_start_during_capture();
        clear_queues();
        pulse_start();
        send_frame(-1, -1, 2, 4, 1'b0);
        send_frame(-1, -1, -1, -1, 1'b0);
        idle(4);
        tests++;
        if (act_w.size() != WORDS || exp_w.size() != WORDS) begin
            fails++;
            $display("FAIL restart_nwrites: got %0d want %0d", act_w.size(), WORDS);
        end
        for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
            tests++;
            if (act_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL restart_write[%0d]: got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_w[i].cyc, act_w[i].addr, act_w[i].data,
                         exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        tests++;
        if (act_d.size() != 1 || exp_d.size() != 1 || act_d[0] !== exp_d[0]) begin
            fails++;
            $display("FAIL restart_done: got %0d dones want exactly 1 with err 0", act_d.size());
        end
        tests++;
        if (busy !== 1'b0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL restart_idle: got busy %b err %b want busy 0 err 0", busy, frame_err);
        end
    endtask

    task automatic test_coincident_sync();
        clear_queues();
        pulse_start();
        send_frame(0, -1, -1, -1, 1'b1);
        send_frame(0, -1, -1, -1, 1'b1);
        idle(4);
        tests++;
        if (act_w.size() == 0 || act_w[0].data !== 12'h012 || act_w[0].addr != 0) begin
            fails++;
            $display("FAIL coincident_first: got %0d writes first data %h want first data 012 addr 0",
                     act_w.size(), (act_w.size() > 0) ? act_w[0].data : 12'hxxx);
        end
        tests++;
        if (act_w.size() != exp_w.size()) begin
            fails++;
            $display("FAIL coincident_nwrites: got %0d want %0d", act_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
            tests++;
            if (act_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL coincident_write[%0d]: got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_w[i].cyc, act_w[i].addr, act_w[i].data,
                         exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        tests++;
        if (act_d.size() != 1 || exp_d.size() != 1 || act_d[0] !== exp_d[0]) begin
            fails++;
            $display("FAIL coincident_done: got %0d dones want 1 at cyc %0d",
                     act_d.size(), (exp_d.size() > 0) ? exp_d[0].cyc : -1);
        end
    endtask

    initial begin
        test_reset();
        test_pattern_frame();
        test_midframe_start();
        test_truncated_line();
        test_start_during_capture();
        test_coincident_sync();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
